// File: rtl/ins_buf.sv
// Instruction parcel buffer: circular queue of 16-bit parcels between fetch and decode.
// Define PREDECODE_EN to add per-entry control-transfer flags (ins_br / has_br).
module ins_buf #(
    parameter int RV    = 32,
    parameter int NP    = 2,
    parameter int DEPTH = 8,
    localparam int SW   = (NP > 1) ? $clog2(NP) : 1,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_valid,
    output logic              fetch_ready,
    input  logic [16*NP-1:0]  fetch_data,
    input  logic [RV-1:0]     fetch_pc,
    input  logic [SW-1:0]     fetch_skip,
    input  logic              flush,
    output logic [15:0]       ins,
    output logic [RV-1:0]     ins_pc,
    output logic              ins_valid,
    input  logic              ins_take,
    output logic [CW-1:0]     count,
    output logic              ins_br,
    output logic              has_br
);

    logic [15:0]    parcel_mem [DEPTH];
    logic [RV-1:0]  pc_mem     [DEPTH];

    logic [AW-1:0]  rptr_q, rptr_d;
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [CW-1:0]  count_q, count_d;

    logic           push;
    logic           pop;
    logic [CW-1:0]  push_n;
    logic [16*NP-1:0] shifted;
    logic [15:0]    wr_parcel [NP];
    logic [RV-1:0]  wr_pc     [NP];
    logic [NP-1:0]  wr_en;

    // Space check uses only the registered count; a same-cycle pop never frees room.
    assign fetch_ready = (CW'(DEPTH) - count_q) >= CW'(NP);
    assign ins_valid   = (count_q != '0);
    assign push        = fetch_valid && fetch_ready && !flush;
    assign pop         = ins_valid && ins_take && !flush;
    assign push_n      = CW'(NP) - CW'(fetch_skip);
    assign shifted     = fetch_data >> {fetch_skip, 4'b0000};

    // Slot gi carries source parcel fetch_skip+gi, destined for wptr+gi.
    for (genvar gi = 0; gi < NP; gi++) begin : g_slot
        assign wr_parcel[gi] = shifted[16*gi +: 16];
        assign wr_pc[gi]     = fetch_pc + (RV'(fetch_skip) << 1) + RV'(2 * gi);
        assign wr_en[gi]     = push && (CW'(gi) < push_n);
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < NP; j++) begin
            if (wr_en[j]) begin
                parcel_mem[wptr_q + AW'(j)] <= wr_parcel[j];
                pc_mem[wptr_q + AW'(j)]     <= wr_pc[j];
            end
        end
    end

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + AW'(push_n);
            if (pop)  rptr_d = rptr_q + AW'(1);
            count_d = count_q + (push ? push_n : CW'(0)) - (pop ? CW'(1) : CW'(0));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign ins    = ins_valid ? parcel_mem[rptr_q] : 16'h0000;
    assign ins_pc = ins_valid ? pc_mem[rptr_q]     : '0;

`ifdef PREDECODE_EN
    logic [DEPTH-1:0] brv_q, brv_d;
    logic             has_br_q;

    function automatic logic is_cti(input logic [15:0] p);
        logic r;
        case (p[1:0])
            2'b01:   r = (p[15:13] == 3'b001) || (p[15:13] == 3'b101) || (p[15:14] == 2'b11);
            2'b11:   r = (p[15:14] == 2'b11);
            2'b10:   r = (p[15:13] == 3'b100) && (p[6:2] == 5'b00000);
            default: r = (p[15:13] == 3'b100);
        endcase
        return r;
    endfunction

    // Flags live only on occupied entries, so the OR of the vector is has_br directly.
    always_comb begin
        brv_d = brv_q;
        if (flush) begin
            brv_d = '0;
        end else begin
            if (pop) brv_d[rptr_q] = 1'b0;
            for (int j = 0; j < NP; j++) begin
                if (wr_en[j]) brv_d[wptr_q + AW'(j)] = is_cti(wr_parcel[j]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            brv_q    <= '0;
            has_br_q <= 1'b0;
        end else begin
            brv_q    <= brv_d;
            has_br_q <= |brv_d;
        end
    end

    assign ins_br = ins_valid && brv_q[rptr_q];
    assign has_br = has_br_q;
`else
    assign ins_br = 1'b0;
    assign has_br = 1'b0;
`endif

endmodule

// File: tb/tb_ins_buf.sv
// Self-checking bench for ins_buf: queue-based reference model compared every cycle,
// plus directed literal checks of the main scenarios.
module tb_ins_buf;
    localparam int RV = 32, NP = 2, DEPTH = 8, SW = 1, CW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              fetch_valid;
    logic              fetch_ready;
    logic [16*NP-1:0]  fetch_data;
    logic [RV-1:0]     fetch_pc;
    logic [SW-1:0]     fetch_skip;
    logic              flush;
    logic [15:0]       ins;
    logic [RV-1:0]     ins_pc;
    logic              ins_valid;
    logic              ins_take;
    logic [CW-1:0]     count;
    logic              ins_br;
    logic              has_br;

    ins_buf #(.RV(RV), .NP(NP), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_data(fetch_data), .fetch_pc(fetch_pc), .fetch_skip(fetch_skip),
        .flush(flush),
        .ins(ins), .ins_pc(ins_pc), .ins_valid(ins_valid), .ins_take(ins_take),
        .count(count), .ins_br(ins_br), .has_br(has_br)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]   p;
        logic [RV-1:0] pc;
    } ent_t;

    ent_t q[$];
    int checks = 0;
    int errors = 0;

    function automatic bit model_cti(input logic [15:0] p);
        logic [2:0] f;
        f = p[15:13];
        case (p[1:0])
            2'b01:   return f inside {3'b001, 3'b101, 3'b110, 3'b111};
            2'b11:   return f inside {3'b110, 3'b111};
            2'b10:   return (f == 3'b100) && (p[6:2] == 5'd0);
            default: return f == 3'b100;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [15:0]   ei;
        logic [RV-1:0] ep;
        bit            hb;
        ei = (q.size() != 0) ? q[0].p  : 16'h0;
        ep = (q.size() != 0) ? q[0].pc : '0;
        hb = 1'b0;
        foreach (q[k]) hb |= model_cti(q[k].p);
        chk("count",       64'(count),       64'(q.size()));
        chk("ins_valid",   64'(ins_valid),   64'(q.size() != 0));
        chk("ins",         64'(ins),         64'(ei));
        chk("ins_pc",      64'(ins_pc),      64'(ep));
        chk("fetch_ready", 64'(fetch_ready), 64'((DEPTH - q.size()) >= NP));
`ifdef PREDECODE_EN
        chk("ins_br",      64'(ins_br),      64'((q.size() != 0) && model_cti(ei)));
        chk("has_br",      64'(has_br),      64'(hb));
`else
        chk("ins_br",      64'(ins_br),      64'(0));
        chk("has_br",      64'(has_br),      64'(0));
`endif
    endtask

    // One clock: apply inputs, advance the model at the edge, compare at the falling edge.
    task automatic cycle(input bit fv, input logic [31:0] d, input logic [RV-1:0] pc,
                         input logic [SW-1:0] sk, input bit fl, input bit tk);
        bit do_push, do_pop;
        fetch_valid = fv; fetch_data = d; fetch_pc = pc;
        fetch_skip  = sk; flush = fl; ins_take = tk;
        do_push = fv && ((DEPTH - q.size()) >= NP) && !fl;
        do_pop  = (q.size() != 0) && tk && !fl;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push)
                for (int i = int'(sk); i < NP; i++)
                    q.push_back(ent_t'{d[16*i +: 16], pc + RV'(2 * i)});
        end
        @(negedge clk);
        compare_model();
        $display("cyc fv=%0d sk=%0d fl=%0d tk=%0d -> count=%0d ins=%h pc=%h", fv, sk, fl, tk, count, ins, ins_pc);
    endtask

    task automatic rand_cycles(input int n, input int pv, input int pt);
        for (int c = 0; c < n; c++)
            cycle(($urandom_range(99) < pv), $urandom, {$urandom} & ~32'h1,
                  SW'($urandom_range(NP - 1)), ($urandom_range(99) < 3),
                  ($urandom_range(99) < pt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; fetch_valid = 1'b0; fetch_data = '0; fetch_pc = '0;
        fetch_skip = '0; flush = 1'b0; ins_take = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_valid", 64'(ins_valid), 64'(0));
        chk("rst_ready", 64'(fetch_ready), 64'(1));
        chk("rst_ins",   64'(ins), 64'(0));
        chk("rst_pc",    64'(ins_pc), 64'(0));
        chk("rst_br",    64'(ins_br), 64'(0));
        chk("rst_hasbr", 64'(has_br), 64'(0));
        reset = 1'b0;

        // Basic push and take
        cycle(1, 32'h4501_0001, 32'h100, 0, 0, 0);
        chk("t1_ins", 64'(ins), 64'h0001);
        chk("t1_pc", 64'(ins_pc), 64'h100);
        chk("t1_count", 64'(count), 64'(2));
        cycle(0, 0, 0, 0, 0, 1);
        chk("t1_ins2", 64'(ins), 64'h4501);
        chk("t1_pc2", 64'(ins_pc), 64'h102);

        // Leading-parcel skip
        cycle(0, 0, 0, 0, 1, 0);
        cycle(1, 32'hAAAA_BBBB, 32'h200, 1, 0, 0);
        chk("t2_count", 64'(count), 64'(1));
        chk("t2_ins", 64'(ins), 64'hAAAA);
        chk("t2_pc", 64'(ins_pc), 64'h202);

        // Fill to full; excess push ignored
        cycle(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 4; k++) cycle(1, $urandom, 32'h400 + 32'(4 * k), 0, 0, 0);
        chk("t3_full", 64'(count), 64'(8));
        chk("t3_ready", 64'(fetch_ready), 64'(0));
        cycle(1, 32'h1234_5678, 32'h500, 0, 0, 0);
        chk("t3_hold", 64'(count), 64'(8));
        cycle(0, 0, 0, 0, 1, 0);
        cycle(1, $urandom, 32'h600, 1, 0, 0);
        for (int k = 0; k < 3; k++) cycle(1, $urandom, 32'h604 + 32'(4 * k), 0, 0, 0);
        chk("t3_c7", 64'(count), 64'(7));
        chk("t3_ready7", 64'(fetch_ready), 64'(0));

        // Simultaneous push and take
        cycle(0, 0, 0, 0, 1, 0);
        cycle(1, $urandom, 32'h700, 0, 0, 0);
        cycle(1, $urandom, 32'h704, 0, 0, 0);
        cycle(1, $urandom, 32'h708, 0, 0, 1);
        chk("t4_count", 64'(count), 64'(5));

        // Flush overrides push and take
        cycle(0, 0, 0, 0, 1, 0);
        cycle(1, $urandom, 32'h800, 1, 0, 0);
        cycle(1, $urandom, 32'h804, 0, 0, 0);
        cycle(1, $urandom, 32'h808, 0, 1, 1);
        chk("t5_count", 64'(count), 64'(0));
        chk("t5_valid", 64'(ins_valid), 64'(0));
        chk("t5_ins", 64'(ins), 64'(0));

`ifdef PREDECODE_EN
        cycle(1, 32'h2001_0001, 32'h900, 0, 0, 0);
        chk("t6_hasbr", 64'(has_br), 64'(1));
        chk("t6_insbr0", 64'(ins_br), 64'(0));
        cycle(0, 0, 0, 0, 0, 1);
        chk("t6_insbr1", 64'(ins_br), 64'(1));
        cycle(0, 0, 0, 0, 0, 1);
        chk("t6_hasbr0", 64'(has_br), 64'(0));
`endif

        // Randomised: fill-biased, drain-biased, balanced phases (exercise wrap)
        rand_cycles(800, 80, 40);
        rand_cycles(800, 40, 85);
        rand_cycles(1200, 60, 60);

        // Asynchronous reset between edges
        cycle(1, $urandom, 32'hA00, 0, 0, 0);
        cycle(1, $urandom, 32'hA04, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("arst_count", 64'(count), 64'(0));
        chk("arst_valid", 64'(ins_valid), 64'(0));
        chk("arst_ready", 64'(fetch_ready), 64'(1));
        chk("arst_ins", 64'(ins), 64'(0));
        chk("arst_hasbr", 64'(has_br), 64'(0));
        q.delete();
        fetch_valid = 1'b0; ins_take = 1'b0; flush = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        compare_model();

        rand_cycles(500, 60, 55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
